// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: latches one EX instruction, issues at most one data
// request, aligns/extends load data. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses via ale.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  output logic        ts_ready,
  input  logic        ns_ready,
  output logic        ts_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rw_addr,
  input  logic        ex_rw_en,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_inst,
  output logic [31:0] mem_rw_data,
  output logic [4:0]  mem_rw_addr,
  output logic        mem_rw_en,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic        dreq_we,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_wstrb,
  output logic [31:0] dreq_wdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        ale,
`endif
  input  logic        dresp_valid,
  input  logic [31:0] dresp_rdata
);

  localparam logic [31:0] ADDR_INVALID     = 32'h0000_0000;
  localparam logic [31:0] DATA_INVALID     = 32'h0000_0000;
  localparam logic [4:0]  REG_ADDR_INVALID = 5'd0;
  localparam logic        EN_INVALID       = 1'b0;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_LD_B  = 4'd1;
  localparam logic [3:0] OP_LD_H  = 4'd2;
  localparam logic [3:0] OP_LD_W  = 4'd3;
  localparam logic [3:0] OP_LD_BU = 4'd4;
  localparam logic [3:0] OP_LD_HU = 4'd5;
  localparam logic [3:0] OP_ST_B  = 4'd6;
  localparam logic [3:0] OP_ST_H  = 4'd7;
  localparam logic [3:0] OP_ST_W  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rw_addr_q, rw_addr_d;
  logic        rw_en_q, rw_en_d;
  logic [31:0] rw_data_q, rw_data_d;

  logic        accept;
  logic        in_is_mem;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

`ifdef MEM_ALIGN_CHECK_EN
  logic ale_q, ale_d;
  logic in_misaligned;

  always_comb begin
    in_misaligned = 1'b0;
    case (ex_mem_op)
      OP_LD_H, OP_LD_HU, OP_ST_H: in_misaligned = ex_alu_result[0];
      OP_LD_W, OP_ST_W:           in_misaligned = |ex_alu_result[1:0];
      default:                    in_misaligned = 1'b0;
    endcase
  end

  assign ale = ale_q && (state_q == S_DONE);
`endif

  // Handshake: stall and flush both veto acceptance even when ts_ready is high.
  assign ts_valid  = (state_q == S_DONE) && !stall;
  assign ts_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && ns_ready && !stall);
  assign accept    = ls_valid && ts_ready && !stall && !flush;
  assign in_is_mem = (ex_mem_op >= OP_LD_B) && (ex_mem_op <= OP_ST_W);

  // Request payload comes only from latched state, so it cannot move while in REQ.
  assign dreq_valid = (state_q == S_REQ);
  assign dreq_addr  = {addr_q[31:2], 2'b00};
  assign dreq_we    = (op_q == OP_ST_B) || (op_q == OP_ST_H) || (op_q == OP_ST_W);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dreq_wstrb = 4'h0;
    dreq_wdata = sdata_q;
    case (op_q)
      OP_ST_B: begin
        dreq_wstrb = 4'b0001 << addr_q[1:0];
        dreq_wdata = {4{sdata_q[7:0]}};
      end
      OP_ST_H: begin
        dreq_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        dreq_wdata = {2{sdata_q[15:0]}};
      end
      OP_ST_W: dreq_wstrb = 4'hF;
      default: dreq_wstrb = 4'h0;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd1:    byte_lane = dresp_rdata[15:8];
      2'd2:    byte_lane = dresp_rdata[23:16];
      2'd3:    byte_lane = dresp_rdata[31:24];
      default: byte_lane = dresp_rdata[7:0];
    endcase
    half_lane = addr_q[1] ? dresp_rdata[31:16] : dresp_rdata[15:0];
    case (op_q)
      OP_LD_B:  load_data = {{24{byte_lane[7]}}, byte_lane};
      OP_LD_H:  load_data = {{16{half_lane[15]}}, half_lane};
      OP_LD_W:  load_data = dresp_rdata;
      OP_LD_BU: load_data = {24'd0, byte_lane};
      OP_LD_HU: load_data = {16'd0, half_lane};
      default:  load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    op_d      = op_q;
    rw_addr_d = rw_addr_q;
    rw_en_d   = rw_en_q;
    rw_data_d = rw_data_q;
`ifdef MEM_ALIGN_CHECK_EN
    ale_d     = ale_q;
`endif

    case (state_q)
      S_REQ: begin
        if (flush)           state_d = dreq_ready ? S_DRAIN : S_IDLE;
        else if (dreq_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = dresp_valid ? S_IDLE : S_DRAIN;
        end else if (dresp_valid) begin
          state_d   = S_DONE;
          rw_data_d = load_data;
        end
      end
      S_DONE: begin
        if (flush || (ns_ready && !stall)) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (dresp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new instruction overrides the IDLE return chosen above (back-to-back from DONE).
    if (accept) begin
      pc_d      = ex_pc;
      inst_d    = ex_inst;
      addr_d    = ex_alu_result;
      sdata_d   = ex_store_data;
      op_d      = ex_mem_op;
      rw_addr_d = ex_rw_addr;
      rw_en_d   = ex_rw_en;
      rw_data_d = ex_alu_result;
      state_d   = in_is_mem ? S_REQ : S_DONE;
`ifdef MEM_ALIGN_CHECK_EN
      ale_d     = 1'b0;
      if (in_is_mem && in_misaligned) begin
        state_d = S_DONE;
        ale_d   = 1'b1;
        rw_en_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= ADDR_INVALID;
      inst_q    <= DATA_INVALID;
      addr_q    <= 32'd0;
      sdata_q   <= 32'd0;
      op_q      <= OP_NONE;
      rw_addr_q <= REG_ADDR_INVALID;
      rw_en_q   <= EN_INVALID;
      rw_data_q <= DATA_INVALID;
`ifdef MEM_ALIGN_CHECK_EN
      ale_q     <= 1'b0;
`endif
    end else begin
      // NOTE: state updates are non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      op_q      <= op_d;
      rw_addr_q <= rw_addr_d;
      rw_en_q   <= rw_en_d;
      rw_data_q <= rw_data_d;
`ifdef MEM_ALIGN_CHECK_EN
      ale_q     <= ale_d;
`endif
    end
  end

  assign mem_pc      = pc_q;
  assign mem_inst    = inst_q;
  assign mem_rw_data = rw_data_q;
  assign mem_rw_addr = rw_addr_q;
  assign mem_rw_en   = rw_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, directed multi-cycle sequences,
// randomized transactions against an arithmetic reference model. Honours MEM_ALIGN_CHECK_EN.
module tb_mem_access_unit;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rw_addr;
    logic        rw_en;
    logic        exp_req;
    logic        exp_ale;
    logic        exp_rw_en;
    logic [31:0] exp_rw_data;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, ls_valid, ns_ready, stall, flush;
  logic        ts_ready, ts_valid;
  logic [31:0] ex_pc, ex_inst, ex_alu_result, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rw_addr;
  logic        ex_rw_en;
  logic [31:0] mem_pc, mem_inst, mem_rw_data;
  logic [4:0]  mem_rw_addr;
  logic        mem_rw_en;
  logic        dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        ale;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder configuration and capture.
  int          cfg_rdly = 0;
  int          cfg_sdly = 0;
  logic [31:0] cfg_rdata = '0;
  bit          spurious = 0;
  int          n_req = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_wstrb;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ts_ready(ts_ready), .ns_ready(ns_ready), .ts_valid(ts_valid),
    .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_rw_addr(ex_rw_addr), .ex_rw_en(ex_rw_en),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rw_data(mem_rw_data),
    .mem_rw_addr(mem_rw_addr), .mem_rw_en(mem_rw_en),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
`ifdef MEM_ALIGN_CHECK_EN
    .ale(ale),
`endif
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: expected behaviour from plain byte/halfword arithmetic.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input logic [4:0] rw_addr, input logic rw_en);
    vec_t v;
    int unsigned off, b, h;
    off = addr % 4;
    b   = (rdata >> (8 * off)) & 32'hFF;
    h   = (rdata >> (16 * (off / 2))) & 32'hFFFF;
    v = '0;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.rw_addr = rw_addr; v.rw_en = rw_en; v.exp_rw_en = rw_en;
    v.exp_req = (op >= 1 && op <= 8);
    v.exp_rw_data = addr;
    case (op)
      4'd1: v.exp_rw_data = (b >= 128) ? b - 256 : b;
      4'd2: v.exp_rw_data = (h >= 32768) ? h - 65536 : h;
      4'd3: v.exp_rw_data = rdata;
      4'd4: v.exp_rw_data = b;
      4'd5: v.exp_rw_data = h;
      4'd6: begin v.exp_rw_data = 0; v.exp_we = 1; v.exp_wstrb = 4'(1 << off);
              v.exp_wdata = (sdata & 32'hFF) * 32'h0101_0101; end
      4'd7: begin v.exp_rw_data = 0; v.exp_we = 1; v.exp_wstrb = 4'(3 << (2 * (off / 2)));
              v.exp_wdata = (sdata & 32'hFFFF) * 32'h0001_0001; end
      4'd8: begin v.exp_rw_data = 0; v.exp_we = 1; v.exp_wstrb = 4'hF; v.exp_wdata = sdata; end
      default: ;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    if (((op == 2 || op == 5 || op == 7) && (off % 2 != 0)) || ((op == 3 || op == 8) && off != 0)) begin
      v.exp_req = 0; v.exp_ale = 1; v.exp_rw_en = 0; v.exp_rw_data = addr; v.exp_we = 0;
    end
`endif
    return v;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input logic [4:0] rw_addr, input logic req,
                               input logic [31:0] rw_data, input logic we, input logic [3:0] wstrb,
                               input logic [31:0] wdata);
    vec_t v;
    v = '0;
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rw_addr = rw_addr;
    v.rw_en = 1'b1; v.exp_rw_en = 1'b1; v.exp_req = req; v.exp_rw_data = rw_data;
    v.exp_we = we; v.exp_wstrb = wstrb; v.exp_wdata = wdata;
    return v;
  endfunction

  // Memory responder: ready after cfg_rdly REQ cycles, response cfg_sdly cycles after handshake.
  initial begin
    int req_cnt, wait_cnt;
    bit pend, have_prev;
    logic [68:0] prev, cur;
    req_cnt = 0; wait_cnt = 0; pend = 0; have_prev = 0; prev = '0;
    dreq_ready = 0; dresp_valid = 0; dresp_rdata = '0;
    forever begin
      @(negedge clk);
      dreq_ready = 0;
      dresp_valid = 0;
      if (rst) begin
        pend = 0; have_prev = 0; req_cnt = 0;
        continue;
      end
      if (spurious) begin
        dresp_valid = 1; dresp_rdata = 32'h5A5A_5A5A;
      end
      if (pend) begin
        if (wait_cnt == 0) begin
          dresp_valid = 1; dresp_rdata = cfg_rdata; pend = 0;
        end else begin
          wait_cnt--;
        end
      end
      if (dreq_valid) begin
        cur = {dreq_addr, dreq_we, dreq_wstrb, dreq_wdata};
        if (have_prev) check("dreq_payload_stable", 32'(cur == prev), 1);
        prev = cur; have_prev = 1;
        if (req_cnt == cfg_rdly) begin
          dreq_ready = 1; pend = 1; wait_cnt = cfg_sdly;
          cap_addr = dreq_addr; cap_we = dreq_we; cap_wstrb = dreq_wstrb; cap_wdata = dreq_wdata;
          n_req++; req_cnt = 0; have_prev = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0; have_prev = 0;
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rw_addr, input logic rw_en);
    ls_valid = 1; ex_mem_op = op; ex_alu_result = addr; ex_store_data = sdata;
    ex_rw_addr = rw_addr; ex_rw_en = rw_en; ex_pc = $urandom; ex_inst = $urandom;
  endtask

  task automatic run_txn(input vec_t v, input int rdly, input int sdly, input string tag);
    logic [31:0] pc, inst;
    int lat, req0, exp_lat;
    @(negedge clk);
    cfg_rdly = rdly; cfg_sdly = sdly; cfg_rdata = v.rdata; req0 = n_req;
    drive(v.op, v.addr, v.sdata, v.rw_addr, v.rw_en);
    pc = ex_pc; inst = ex_inst; ns_ready = 1;
    check({tag, "_ts_ready"}, ts_ready, 1);
    @(posedge clk); #1 ls_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!ts_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    exp_lat = v.exp_req ? 3 + rdly + sdly : 1;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_pc"}, mem_pc, pc);
    check({tag, "_inst"}, mem_inst, inst);
    check({tag, "_rw_addr"}, mem_rw_addr, v.rw_addr);
    check({tag, "_rw_en"}, mem_rw_en, v.exp_rw_en);
    check({tag, "_rw_data"}, mem_rw_data, v.exp_rw_data);
    check({tag, "_req_count"}, n_req - req0, v.exp_req ? 1 : 0);
    if (v.exp_req) begin
      check({tag, "_dreq_addr"}, cap_addr, v.addr & 32'hFFFF_FFFC);
      check({tag, "_dreq_we"}, cap_we, v.exp_we);
      check({tag, "_dreq_wstrb"}, cap_wstrb, v.exp_wstrb);
      if (v.exp_we) check({tag, "_dreq_wdata"}, cap_wdata, v.exp_wdata);
    end
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, "_ale"}, ale, v.exp_ale);
`endif
  endtask

  task automatic start_mem(input logic [3:0] op, input logic [31:0] addr, input int rdly, input int sdly);
    @(negedge clk);
    cfg_rdly = rdly; cfg_sdly = sdly; cfg_rdata = 32'hDEAD_0000;
    drive(op, addr, 32'h1111_2222, 5'd9, 1'b1);
    @(posedge clk); #1 ls_valid = 0;
  endtask

  task automatic drain_watch(input int exp_n, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!ts_ready && n < 20) begin
      check({tag, "_no_valid"}, ts_valid, 0);
      n++;
      @(negedge clk);
    end
    check({tag, "_drain_cycles"}, n, exp_n);
    check({tag, "_valid_after"}, ts_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [0:10];
    vec_t v;
    tbl[0]  = mkv(4'd0, 32'h1234_5678, 32'h0,         32'h0,         5'd5,  0, 32'h1234_5678, 0, 4'h0, 32'h0);
    tbl[1]  = mkv(4'd1, 32'h0000_100F, 32'h0,         32'h80FF_0011, 5'd6,  1, 32'hFFFF_FF80, 0, 4'h0, 32'h0);
    tbl[2]  = mkv(4'd4, 32'h0000_100F, 32'h0,         32'h80FF_0011, 5'd7,  1, 32'h0000_0080, 0, 4'h0, 32'h0);
    tbl[3]  = mkv(4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 32'h0,         5'd8,  1, 32'h0,         1, 4'b1100, 32'hBEEF_BEEF);
    tbl[4]  = mkv(4'd2, 32'h0000_2002, 32'h0,         32'h8001_7FFF, 5'd10, 1, 32'hFFFF_8001, 0, 4'h0, 32'h0);
    tbl[5]  = mkv(4'd5, 32'h0000_2000, 32'h0,         32'h8001_F00D, 5'd11, 1, 32'h0000_F00D, 0, 4'h0, 32'h0);
    tbl[6]  = mkv(4'd3, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF, 5'd12, 1, 32'hDEAD_BEEF, 0, 4'h0, 32'h0);
    tbl[7]  = mkv(4'd6, 32'h0000_5001, 32'h1234_56A5, 32'h0,         5'd13, 1, 32'h0,         1, 4'b0010, 32'hA5A5_A5A5);
    tbl[8]  = mkv(4'd8, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,         5'd14, 1, 32'h0,         1, 4'hF, 32'hCAFE_F00D);
    tbl[9]  = mkv(4'd12, 32'h0BAD_CAFE, 32'h0,        32'h0,         5'd15, 0, 32'h0BAD_CAFE, 0, 4'h0, 32'h0);
    tbl[10] = mkv(4'd1, 32'h0000_7000, 32'h0,         32'h0000_007F, 5'd16, 1, 32'h0000_007F, 0, 4'h0, 32'h0);
    tbl[9].exp_rw_en = 1'b1;

    rst = 1; ls_valid = 0; ns_ready = 1; stall = 0; flush = 0;
    ex_pc = '0; ex_inst = '0; ex_alu_result = '0; ex_store_data = '0;
    ex_mem_op = '0; ex_rw_addr = '0; ex_rw_en = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_ts_valid", ts_valid, 0);
    check("reset_ts_ready", ts_ready, 1);
    check("reset_dreq_valid", dreq_valid, 0);
    check("reset_mem_pc", mem_pc, 32'h0);
    check("reset_mem_inst", mem_inst, 32'h0);
    check("reset_mem_rw_data", mem_rw_data, 32'h0);
    check("reset_mem_rw_addr", mem_rw_addr, 0);
    check("reset_mem_rw_en", mem_rw_en, 0);
`ifdef MEM_ALIGN_CHECK_EN
    check("reset_ale", ale, 0);
`endif

    for (int i = 0; i < 11; i++) run_txn(tbl[i], 0, 0, $sformatf("vec%0d", i));

    // Three cycles of dreq_ready low: payload held, result three cycles later.
    run_txn(tbl[3], 3, 0, "st_h_ready_delay");
    run_txn(tbl[6], 1, 2, "ld_w_both_delay");

    // Stall in DONE, back-to-back acceptance, ns_ready back-pressure, flush in DONE.
    @(negedge clk);
    drive(4'd0, 32'hAAAA_0001, 32'h0, 5'd1, 1'b1);
    @(posedge clk); #1 ex_alu_result = 32'hBBBB_0002; stall = 1;
    @(negedge clk);
    check("stall_masks_valid", ts_valid, 0);
    check("stall_blocks_ready", ts_ready, 0);
    @(posedge clk); #1 stall = 0;
    @(negedge clk);
    check("stall_release_valid", ts_valid, 1);
    check("stall_held_data", mem_rw_data, 32'hAAAA_0001);
    check("done_ready", ts_ready, 1);
    @(posedge clk); #1 ls_valid = 0; ns_ready = 0;
    @(negedge clk);
    check("b2b_valid", ts_valid, 1);
    check("b2b_data", mem_rw_data, 32'hBBBB_0002);
    check("backpressure_ready", ts_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("backpressure_hold", ts_valid, 1);
    flush = 1;
    @(posedge clk); #1 flush = 0; ns_ready = 1;
    @(negedge clk);
    check("flush_done_valid", ts_valid, 0);
    check("flush_done_ready", ts_ready, 1);

    // A response while IDLE must be ignored.
    @(posedge clk); #1 spurious = 1;
    @(posedge clk); #1 spurious = 0;
    @(negedge clk);
    check("spurious_valid", ts_valid, 0);
    check("spurious_ready", ts_ready, 1);

    // Flush in WAIT, response two cycles later: drain then IDLE.
    start_mem(4'd3, 32'h0000_9000, 0, 2);
    @(negedge clk);
    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
    drain_watch(2, "flush_wait");

    // Flush in REQ on the handshake cycle also drains.
    start_mem(4'd3, 32'h0000_A000, 0, 1);
    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
    drain_watch(2, "flush_req_hs");

    // Flush in WAIT with the response in the same cycle: straight to IDLE.
    start_mem(4'd3, 32'h0000_B000, 0, 0);
    @(negedge clk);
    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
    drain_watch(0, "flush_wait_resp");

    // Flush in REQ before the handshake: request withdrawn.
    start_mem(4'd8, 32'h0000_C000, 5, 0);
    @(negedge clk);
    check("flush_req_pre_valid", dreq_valid, 1);
    flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("flush_req_withdrawn", dreq_valid, 0);
    check("flush_req_ready", ts_ready, 1);

    // Reset while waiting for a response.
    start_mem(4'd3, 32'h0000_8000, 0, 3);
    @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst_ready", ts_ready, 1);
    check("midrst_dreq_valid", dreq_valid, 0);
    check("midrst_mem_pc", mem_pc, 32'h0);
    repeat (4) @(negedge clk);
    check("midrst_no_valid", ts_valid, 0);

`ifdef MEM_ALIGN_CHECK_EN
    v = '0;
    v.op = 4'd3; v.addr = 32'h0000_3001; v.rw_addr = 5'd3; v.rw_en = 1'b1;
    v.exp_ale = 1'b1; v.exp_rw_en = 1'b0; v.exp_rw_data = 32'h0000_3001;
    run_txn(v, 0, 0, "misaligned_ld_w");
`endif

    for (int i = 0; i < 150; i++) begin
      v = model(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      run_txn(v, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
